line_clear_scan: RTL and testbench

- Sequential row scanner that runs directly upstream of the line-compaction stage.
- After a piece locks, it snapshots the board, scans one row per clock and finds every complete row.
- It produces a board with those rows set to EMPTY, plus a row mask and a line count.
- The compaction stage consumes the cleared board to drop the remaining rows; game control uses the count for scoring and level.

---
 rtl/line_clear_scan_if.sv | 46 ++++
 rtl/line_clear_scan.sv | 132 +++++++++++++
 tb/tb_line_clear_scan.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_clear_scan_if.sv
// Cell type shared by the scanner and its neighbours, plus the scanner's request/result bundle.
// Optional scoring is enabled by the LINE_CLEAR_SCORE_EN macro in the scanner itself.
package line_clear_scan_pkg;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        CYAN   = 3'd1,
        YELLOW = 3'd2,
        PURPLE = 3'd3,
        GREEN  = 3'd4,
        RED    = 3'd5,
        BLUE   = 3'd6,
        ORANGE = 3'd7
    } block_color;

endpackage

interface line_clear_scan_if #(
    parameter int unsigned X_SIZE = 10,
    parameter int unsigned Y_SIZE = 20
);
    import line_clear_scan_pkg::*;

    localparam int unsigned LINES_W = 5;
    localparam int unsigned SCORE_W = 11;

    logic                 start;
    block_color           board_in  [X_SIZE][Y_SIZE];
    logic                 busy;
    logic                 done;
    block_color           board_out [X_SIZE][Y_SIZE];
    logic [Y_SIZE-1:0]    full_mask;
    logic [LINES_W-1:0]   lines_cleared;
    logic [SCORE_W-1:0]   score_delta;

    modport master (
        output start, board_in,
        input  busy, done, board_out, full_mask, lines_cleared, score_delta
    );

    modport slave (
        input  start, board_in,
        output busy, done, board_out, full_mask, lines_cleared, score_delta
    );

endinterface

// File: rtl/line_clear_scan.sv
// Row scanner feeding line compaction: snapshots the board, tests one row per clock, empties full rows.
// Define LINE_CLEAR_SCORE_EN to register a score for the clear; otherwise score_delta is tied to zero.
module line_clear_scan
    import line_clear_scan_pkg::*;
#(
    parameter int unsigned X_SIZE = 10,
    parameter int unsigned Y_SIZE = 20
) (
    input  logic             Clk,
    input  logic             Reset_n,
    line_clear_scan_if.slave bus
);

    localparam int unsigned ROW_W = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam int unsigned CNT_W = 5;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(Y_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    block_color        snapshot [X_SIZE][Y_SIZE];
    logic [Y_SIZE-1:0] work_mask;
    logic [CNT_W-1:0]  work_count;
    logic [ROW_W-1:0]  row_idx;
    logic              row_full_c;

    // A row is full when no column of the current snapshot row is EMPTY.
    always_comb begin
        row_full_c = 1'b1;
        for (int unsigned x = 0; x < X_SIZE; x++) begin
            if (snapshot[x][row_idx] == EMPTY) begin
                row_full_c = 1'b0;
            end
        end
    end

    // Scan sequencer; row_idx parks on the last row so it never indexes past the board.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state             <= IDLE;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.full_mask     <= '0;
            bus.lines_cleared <= '0;
            work_mask         <= '0;
            work_count        <= '0;
            row_idx           <= '0;
            for (int unsigned x = 0; x < X_SIZE; x++) begin
                for (int unsigned y = 0; y < Y_SIZE; y++) begin
                    snapshot[x][y]      <= EMPTY;
                    bus.board_out[x][y] <= EMPTY;
                end
            end
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        snapshot   <= bus.board_in;
                        work_mask  <= '0;
                        work_count <= '0;
                        row_idx    <= '0;
                        bus.busy   <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_full_c) begin
                        work_mask[row_idx] <= 1'b1;
                        work_count         <= work_count + CNT_W'(1);
                    end
                    if (row_idx == LAST_ROW) begin
                        state <= CLEAR;
                    end else begin
                        row_idx <= row_idx + ROW_W'(1);
                    end
                end
                CLEAR: begin
                    for (int unsigned x = 0; x < X_SIZE; x++) begin
                        for (int unsigned y = 0; y < Y_SIZE; y++) begin
                            bus.board_out[x][y] <= work_mask[y] ? EMPTY : snapshot[x][y];
                        end
                    end
                    bus.full_mask     <= work_mask;
                    bus.lines_cleared <= work_count;
                    bus.done          <= 1'b1;
                    state             <= DONE;
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    localparam int unsigned SCORE_W = 11;

    // Classic line-clear table; four or more lines score as a four-line clear.
    function automatic logic [SCORE_W-1:0] score_of(input logic [CNT_W-1:0] lines);
        logic [SCORE_W-1:0] pts;
        case (lines)
            CNT_W'(0): pts = SCORE_W'(0);
            CNT_W'(1): pts = SCORE_W'(40);
            CNT_W'(2): pts = SCORE_W'(100);
            CNT_W'(3): pts = SCORE_W'(300);
            default:   pts = SCORE_W'(1200);
        endcase
        return pts;
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.score_delta <= '0;
        end else if (state == CLEAR) begin
            bus.score_delta <= score_of(work_count);
        end
    end
`else
    assign bus.score_delta = '0;
`endif

endmodule

// File: tb/tb_line_clear_scan.sv
// Randomised and directed checks of line_clear_scan against a row-counting reference model.
// Honours LINE_CLEAR_SCORE_EN for the expected score.
module tb_line_clear_scan;
    import line_clear_scan_pkg::*;

    localparam int unsigned X = 10;
    localparam int unsigned Y = 20;

    typedef block_color board_t [X][Y];

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    line_clear_scan_if #(.X_SIZE(X), .Y_SIZE(Y)) bus ();

    line_clear_scan #(.X_SIZE(X), .Y_SIZE(Y)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    board_t       snap;
    board_t       exp_board;
    logic [Y-1:0] exp_mask;
    int           exp_lines;
    int           exp_score;
    int           busy_cnt;
    int           done_cnt;
    int           done_cyc;

    function automatic block_color rand_color();
        return block_color'(3'($urandom_range(1, 7)));
    endfunction

    task automatic clear_snap();
        for (int x = 0; x < X; x++)
            for (int y = 0; y < Y; y++)
                snap[x][y] = EMPTY;
    endtask

    // Full rows get every cell coloured; other rows are random with at least one hole.
    task automatic make_board(input logic [Y-1:0] full_rows);
        for (int y = 0; y < Y; y++) begin
            for (int x = 0; x < X; x++)
                snap[x][y] = (full_rows[y] || $urandom_range(0, 1) == 1) ? rand_color() : EMPTY;
            if (!full_rows[y])
                snap[$urandom_range(0, X - 1)][y] = EMPTY;
        end
    endtask

    // Reference: count occupied cells per row, a row is full when the count reaches X.
    task automatic model();
        exp_lines = 0;
        exp_mask  = '0;
        for (int y = 0; y < Y; y++) begin
            int filled = 0;
            for (int x = 0; x < X; x++)
                if (snap[x][y] != EMPTY) filled++;
            exp_mask[y] = (filled == X);
            if (filled == X) exp_lines++;
            for (int x = 0; x < X; x++)
                exp_board[x][y] = (filled == X) ? EMPTY : snap[x][y];
        end
`ifdef LINE_CLEAR_SCORE_EN
        case (exp_lines)
            0:       exp_score = 0;
            1:       exp_score = 40;
            2:       exp_score = 100;
            3:       exp_score = 300;
            default: exp_score = 1200;
        endcase
`else
        exp_score = 0;
`endif
    endtask

    task automatic check_results(input string tag);
        int bad = 0;
        for (int x = 0; x < X; x++)
            for (int y = 0; y < Y; y++)
                if (bus.board_out[x][y] !== exp_board[x][y]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s board_out: %0d cells differ, want 0", tag, bad);
        end
        checks++;
        if (bus.full_mask !== exp_mask) begin
            errors++;
            $display("FAIL %s full_mask: got %h want %h", tag, bus.full_mask, exp_mask);
        end
        checks++;
        if (bus.lines_cleared !== 5'(exp_lines)) begin
            errors++;
            $display("FAIL %s lines_cleared: got %0d want %0d", tag, bus.lines_cleared, exp_lines);
        end
        checks++;
        if (bus.score_delta !== 11'(exp_score)) begin
            errors++;
            $display("FAIL %s score_delta: got %0d want %0d", tag, bus.score_delta, exp_score);
        end
    endtask

    // Issue one scan of snap; optionally pulse start again at cycle pulse_at and scramble board_in.
    task automatic run_scan(input string tag, input int pulse_at, input bit mutate);
        @(negedge Clk);
        bus.board_in = snap;
        bus.start    = 1'b1;
        model();
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge Clk);
            bus.start = (c == pulse_at);
            if (mutate && c == 3)
                for (int x = 0; x < X; x++)
                    for (int y = 0; y < Y; y++)
                        bus.board_in[x][y] = rand_color();
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
            if (bus.busy !== 1'b1) break;
        end
        bus.start = 1'b0;
        checks++;
        if (busy_cnt != Y + 2) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_cnt, Y + 2);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt);
        end
        checks++;
        if (done_cyc != Y + 2) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d want %0d", tag, done_cyc, Y + 2);
        end
        check_results(tag);
    endtask

    task automatic check_cleared_outputs(input string tag);
        int bad = 0;
        for (int x = 0; x < X; x++)
            for (int y = 0; y < Y; y++)
                if (bus.board_out[x][y] !== EMPTY) bad++;
        checks++;
        if (bad != 0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s reset_ctrl: busy %b done %b nonempty %0d want 0 0 0", tag, bus.busy, bus.done, bad);
        end
        checks++;
        if (bus.full_mask !== '0 || bus.lines_cleared !== '0 || bus.score_delta !== '0) begin
            errors++;
            $display("FAIL %s reset_results: mask %h lines %0d score %0d want 0", tag,
                     bus.full_mask, bus.lines_cleared, bus.score_delta);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        clear_snap();
        bus.board_in = snap;
        Reset_n = 1'b0;
        #3;
        check_cleared_outputs("reset");
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_empty_board();
        clear_snap();
        run_scan("empty", 0, 1'b0);
    endtask

    task automatic test_single_row();
        clear_snap();
        for (int x = 0; x < X; x++) snap[x][19] = rand_color();
        for (int x = 0; x < 9; x++) snap[x][18] = rand_color();
        run_scan("single_row", 0, 1'b0);
        checks++;
        if (bus.full_mask !== 20'h80000) begin
            errors++;
            $display("FAIL single_row mask_literal: got %h want 80000", bus.full_mask);
        end
    endtask

    task automatic test_four_rows();
        make_board(20'hA9000);
        run_scan("four_rows", 0, 1'b0);
        checks++;
        if (bus.full_mask !== 20'hA9000 || bus.lines_cleared !== 5'd4) begin
            errors++;
            $display("FAIL four_rows literal: mask %h lines %0d want A9000 4", bus.full_mask, bus.lines_cleared);
        end
    endtask

    task automatic test_all_full();
        make_board('1);
        run_scan("all_full", Y + 2, 1'b0);
        checks++;
        if (bus.lines_cleared !== 5'd20 || bus.full_mask !== 20'hFFFFF) begin
            errors++;
            $display("FAIL all_full literal: mask %h lines %0d want FFFFF 20", bus.full_mask, bus.lines_cleared);
        end
    endtask

    task automatic test_start_ignored();
        make_board(20'h01234);
        run_scan("start_ignored", 5, 1'b1);
    endtask

    task automatic test_reset_mid_scan();
        int done_seen = 0;
        make_board(20'h00F0F);
        @(negedge Clk);
        bus.board_in = snap;
        bus.start    = 1'b1;
        @(negedge Clk);
        bus.start = 1'b0;
        repeat (9) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check_cleared_outputs("mid_reset");
        repeat (3) begin
            @(negedge Clk);
            if (bus.done !== 1'b0) done_seen++;
        end
        Reset_n = 1'b1;
        repeat (25) begin
            @(negedge Clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL mid_reset stray_activity: got %0d cycles want 0", done_seen);
        end
        make_board(20'h30001);
        run_scan("after_reset", 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            logic [Y-1:0] rows;
            rows = Y'($urandom & $urandom);
            make_board(rows);
            run_scan($sformatf("random%0d", i), (i % 3 == 0) ? int'($urandom_range(1, Y + 2)) : 0, i[0]);
        end
    endtask

    initial begin
        test_reset();
        test_empty_board();
        test_single_row();
        test_four_rows();
        test_all_full();
        test_reset_mid_scan();
        test_start_ignored();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
